// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and sizing helpers for piso_serializer
// Defining PISO_PARITY_EN adds one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Frame length in cycles: the data bits plus the optional parity bit.
  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - word handshake and serial-side signals of piso_serializer
// master is the word source / serial sink, slave is the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - modulo-N bit index counter with terminal-count flag
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with frame markers
// PISO_PARITY_EN appends an even-parity bit after the data bits of each frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  piso_serializer_if.slave        bus
);

  localparam int CW = cnt_width(WIDTH);

  piso_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_idx;
  logic             last_data;
  logic             accept;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_first_q;
  logic             ser_last_q;
  logic             busy_q;
`ifdef PISO_PARITY_EN
  logic             parity_q;
`endif

  // Index of the bit currently on ser_out; wraps to 0 on the last data bit.
  piso_bit_counter #(.N(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (state == ST_SHIFT),
    .count (bit_idx),
    .tc    (last_data)
  );

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

`ifdef PISO_PARITY_EN
  assign bus.in_ready = !rst && ((state == ST_IDLE) || (state == ST_PARITY));
`else
  assign bus.in_ready = !rst && ((state == ST_IDLE) || ((state == ST_SHIFT) && last_data));
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (accept) begin
      // First bit goes straight to the output; the rest wait in shreg.
      state       <= ST_SHIFT;
      shreg       <= advance(bus.in_data);
      ser_out_q   <= head(bus.in_data);
      ser_valid_q <= 1'b1;
      ser_first_q <= 1'b1;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef PISO_PARITY_EN
      parity_q    <= ^bus.in_data;
`endif
    end else begin
      case (state)
        ST_SHIFT: begin
          ser_first_q <= 1'b0;
          if (last_data) begin
`ifdef PISO_PARITY_EN
            state       <= ST_PARITY;
            shreg       <= '0;
            ser_out_q   <= parity_q;
            ser_last_q  <= 1'b1;
`else
            state       <= ST_IDLE;
            shreg       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`endif
          end else begin
            shreg     <= advance(shreg);
            ser_out_q <= head(shreg);
`ifdef PISO_PARITY_EN
            ser_last_q <= 1'b0;
`else
            ser_last_q <= (bit_idx == CW'(WIDTH - 2));
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          state       <= ST_IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_first_q <= 1'b0;
          ser_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
// Expects a 9-cycle frame when PISO_PARITY_EN is defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) m ();
  piso_serializer_if #(.WIDTH(8)) l ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(m));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(l));

  // Expected frame bit i of word d; index 8 is the even-parity bit.
  function automatic logic exp_bit(input logic [7:0] d, input int i, input bit msb);
    if (i >= 8) return ^d;
    return msb ? d[7-i] : d[i];
  endfunction

  task automatic test_reset;
    m.in_valid = 1'b0; m.in_data = '0;
    l.in_valid = 1'b0; l.in_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({m.ser_out, m.ser_valid, m.ser_first, m.ser_last, m.busy, m.in_ready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_msb: got %b want 000000", {m.ser_out, m.ser_valid, m.ser_first, m.ser_last, m.busy, m.in_ready});
    end
    tests_run++;
    if ({l.ser_out, l.ser_valid, l.ser_first, l.ser_last, l.busy, l.in_ready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_lsb: got %b want 000000", {l.ser_out, l.ser_valid, l.ser_first, l.ser_last, l.busy, l.in_ready});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (m.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle_ready: got %b want 1", m.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_word;
    logic [7:0] d = 8'hA5;
    logic [4:0] exp;
    m.in_data = d; m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      exp = {1'b1, 1'b1, exp_bit(d, i, 1'b1), i == 0, i == FL - 1};
      tests_run++;
      if ({m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last} !== exp) begin
        tests_failed++;
        $display("FAIL single_word bit %0d: vld/busy/out/first/last got %b want %b", i,
                 {m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last}, exp);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last} !== 5'b0) begin
      tests_failed++;
      $display("FAIL single_word_end: got %b want 00000", {m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last});
    end
  endtask

  task automatic test_lsb_order;
    logic [7:0] d = 8'h01;
    logic [4:0] exp;
    l.in_data = d; l.in_valid = 1'b1;
    @(negedge clk);
    l.in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      exp = {1'b1, 1'b1, exp_bit(d, i, 1'b0), i == 0, i == FL - 1};
      tests_run++;
      if ({l.ser_valid, l.busy, l.ser_out, l.ser_first, l.ser_last} !== exp) begin
        tests_failed++;
        $display("FAIL lsb_order bit %0d: got %b want %b", i,
                 {l.ser_valid, l.busy, l.ser_out, l.ser_first, l.ser_last}, exp);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({l.ser_valid, l.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL lsb_order_end: got %b want 00", {l.ser_valid, l.busy});
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp;
    m.in_data = 8'hFF; m.in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2 * FL; i++) begin
      exp = {1'b1, 1'b1, exp_bit((i < FL) ? 8'hFF : 8'h00, i % FL, 1'b1),
             (i == 0) || (i == FL), (i == FL - 1) || (i == 2 * FL - 1),
             (i == FL - 1) || (i == 2 * FL - 1)};
      tests_run++;
      if ({m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last, m.in_ready} !== exp) begin
        tests_failed++;
        $display("FAIL back_to_back cycle %0d: vld/busy/out/first/last/rdy got %b want %b", i + 1,
                 {m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last, m.in_ready}, exp);
      end
      if (i == 0) m.in_data = 8'h00;
      if (i == FL) m.in_valid = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if ({m.ser_valid, m.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL back_to_back_end: got %b want 00", {m.ser_valid, m.busy});
    end
  endtask

  task automatic test_backpressure;
    logic [5:0] exp;
    m.in_data = 8'hC3; m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
    for (int i = 0; i < 2 * FL; i++) begin
      exp = {1'b1, 1'b1, exp_bit((i < FL) ? 8'hC3 : 8'h3C, i % FL, 1'b1),
             (i == 0) || (i == FL), (i == FL - 1) || (i == 2 * FL - 1),
             (i == FL - 1) || (i == 2 * FL - 1)};
      tests_run++;
      if ({m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last, m.in_ready} !== exp) begin
        tests_failed++;
        $display("FAIL backpressure cycle %0d: got %b want %b", i + 1,
                 {m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last, m.in_ready}, exp);
      end
      if (i == 1) begin
        m.in_data = 8'h3C; m.in_valid = 1'b1;
      end
      if (i == FL) m.in_valid = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if ({m.ser_valid, m.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL backpressure_end: got %b want 00", {m.ser_valid, m.busy});
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [4:0] exp;
    m.in_data = 8'hF0; m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (m.ser_out !== exp_bit(8'hF0, i, 1'b1)) begin
        tests_failed++;
        $display("FAIL abort_prefix bit %0d: got %b want %b", i, m.ser_out, exp_bit(8'hF0, i, 1'b1));
      end
      if (i < 3) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (m.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_ready_in_rst: got %b want 0", m.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({m.ser_out, m.ser_valid, m.ser_first, m.ser_last, m.busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got %b want 00000", {m.ser_out, m.ser_valid, m.ser_first, m.ser_last, m.busy});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (m.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_idle: got %b want 1", m.in_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({m.ser_valid, m.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL abort_no_leftover: got %b want 00", {m.ser_valid, m.busy});
    end
    m.in_data = 8'h81; m.in_valid = 1'b1;
    @(negedge clk);
    m.in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      exp = {1'b1, 1'b1, exp_bit(8'h81, i, 1'b1), i == 0, i == FL - 1};
      tests_run++;
      if ({m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last} !== exp) begin
        tests_failed++;
        $display("FAIL after_abort bit %0d: got %b want %b", i,
                 {m.ser_valid, m.busy, m.ser_out, m.ser_first, m.ser_last}, exp);
      end
      @(negedge clk);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       pbit  [2];
    words[0] = 8'h07; pbit[0] = 1'b1;
    words[1] = 8'h03; pbit[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m.in_data = words[w]; m.in_valid = 1'b1;
      @(negedge clk);
      m.in_valid = 1'b0;
      for (int i = 0; i < FL; i++) begin
        tests_run++;
        if (m.ser_last !== (i == FL - 1)) begin
          tests_failed++;
          $display("FAIL parity_last word %0d bit %0d: got %b want %b", w, i, m.ser_last, i == FL - 1);
        end
        if (i == FL - 1) begin
          tests_run++;
          if ({m.ser_valid, m.ser_out} !== {1'b1, pbit[w]}) begin
            tests_failed++;
            $display("FAIL parity_bit word %0d: got %b want %b", w, {m.ser_valid, m.ser_out}, {1'b1, pbit[w]});
          end
        end
        @(negedge clk);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_lsb_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
